// File: rtl/decode_fwd_unit.sv
// Decode-stage operand forwarding and EX/load-use hazard stall over an EX/MEM/WB tag pipeline.
// Defining DECODE_FWD_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module decode_fwd_unit #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NP = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NP*AW-1:0] d_ra,
   input  logic [NP*DW-1:0] d_rd,
   input  logic [NP-1:0]    d_use,
   input  logic             d_valid,
   input  logic             d_we,
   input  logic [AW-1:0]    d_wa,
   input  logic             d_load,
   input  logic             flush_e,
   input  logic [DW-1:0]    alu_out_m,
   input  logic [DW-1:0]    result_w,
   output logic [NP*DW-1:0] d_opnd,
   output logic [2*NP-1:0]  fwd_sel,
   output logic             stall_d
`ifdef DECODE_FWD_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   logic          vld_p0, vld_p1, vld_p2;
   logic          we_p0, we_p1, we_p2;
   logic [AW-1:0] wa_p0, wa_p1, wa_p2;
   logic          load_p0, load_p1;

   logic [NP-1:0] hit_ex, hit_mem, hit_wb, hazard;

   function automatic logic is_prod(input logic vld, input logic we,
                                    input logic [AW-1:0] wa, input logic [AW-1:0] ra);
      return vld && we && (wa == ra) && (ra != '0);
   endfunction

   // p0 = EX, p1 = MEM, p2 = WB; only the valid bits carry reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= d_valid & ~stall_d & ~flush_e;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // The WB load flag is never consulted, so it is not stored
   always_ff @(posedge clk) begin
      we_p0   <= d_we;
      wa_p0   <= d_wa;
      load_p0 <= d_load;
      we_p1   <= we_p0;
      wa_p1   <= wa_p0;
      load_p1 <= load_p0;
      we_p2   <= we_p1;
      wa_p2   <= wa_p1;
   end

   always_comb begin
      d_opnd  = d_rd;
      fwd_sel = '0;
      hit_ex  = '0;
      hit_mem = '0;
      hit_wb  = '0;
      hazard  = '0;
      for (int p = 0; p < NP; p++) begin
         hit_ex[p]  = is_prod(vld_p0, we_p0, wa_p0, d_ra[p*AW +: AW]);
         hit_mem[p] = is_prod(vld_p1, we_p1, wa_p1, d_ra[p*AW +: AW]);
         hit_wb[p]  = is_prod(vld_p2, we_p2, wa_p2, d_ra[p*AW +: AW]);
         if (d_use[p]) begin
            hazard[p] = hit_ex[p] | (hit_mem[p] & load_p1);
            if (hit_mem[p] && !load_p1) begin
               fwd_sel[2*p +: 2] = 2'b01;
               d_opnd[p*DW +: DW] = alu_out_m;
            end else if (hit_wb[p]) begin
               fwd_sel[2*p +: 2] = 2'b10;
               d_opnd[p*DW +: DW] = result_w;
            end
         end
      end
   end

   assign stall_d = d_valid & (|hazard);

`ifdef DECODE_FWD_STALL_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_d) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_decode_fwd_unit.sv
// Bench for decode_fwd_unit: directed vector table, reset corner sequence and random traffic
// checked against an age-based in-flight instruction model.
module tb_decode_fwd_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NP = 2;
   localparam logic [DW-1:0] RD0 = 32'hAAAA_0000;
   localparam logic [DW-1:0] RD1 = 32'hBBBB_0001;
   localparam logic [DW-1:0] ALU = 32'h0000_00A5;
   localparam logic [DW-1:0] RES = 32'h0000_5A5A;

   logic             clk;
   logic             rst_n;
   logic [NP*AW-1:0] d_ra;
   logic [NP*DW-1:0] d_rd;
   logic [NP-1:0]    d_use;
   logic             d_valid, d_we, d_load, flush_e;
   logic [AW-1:0]    d_wa;
   logic [DW-1:0]    alu_out_m, result_w;
   logic [NP*DW-1:0] d_opnd;
   logic [2*NP-1:0]  fwd_sel;
   logic             stall_d;
   logic [15:0]      stall_cnt;

   int n_cmp, n_bad;
   logic [15:0] m_cnt;

   typedef struct {
      logic we; logic [AW-1:0] wa; logic ld; int age;
   } inflight_t;
   inflight_t q[$];

   typedef struct {
      logic v, we; logic [AW-1:0] wa; logic ld;
      logic [AW-1:0] ra0, ra1; logic [1:0] usem; logic fl;
      logic es; logic [3:0] esel;
   } row_t;
   row_t tbl[$];

   decode_fwd_unit #(.DW(DW), .AW(AW), .NP(NP)) dut (
      .clk(clk),
`ifdef DECODE_FWD_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .rst_n(rst_n), .d_ra(d_ra), .d_rd(d_rd), .d_use(d_use), .d_valid(d_valid),
      .d_we(d_we), .d_wa(d_wa), .d_load(d_load), .flush_e(flush_e),
      .alu_out_m(alu_out_m), .result_w(result_w), .d_opnd(d_opnd),
      .fwd_sel(fwd_sel), .stall_d(stall_d)
   );

`ifndef DECODE_FWD_STALL_CNT_EN
   assign stall_cnt = 16'h0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input int v, input int we, input int wa, input int ld,
                         input int ra0, input int ra1, input int usem, input int fl);
      d_valid = v[0]; d_we = we[0]; d_wa = AW'(wa); d_load = ld[0];
      d_ra = {AW'(ra1), AW'(ra0)}; d_use = NP'(usem); flush_e = fl[0];
   endtask

   task automatic add_row(input int v, input int we, input int wa, input int ld, input int ra0,
                          input int ra1, input int usem, input int fl, input int es, input int esel);
      row_t r;
      r.v = v[0]; r.we = we[0]; r.wa = AW'(wa); r.ld = ld[0];
      r.ra0 = AW'(ra0); r.ra1 = AW'(ra1); r.usem = 2'(usem); r.fl = fl[0];
      r.es = es[0]; r.esel = 4'(esel);
      tbl.push_back(r);
   endtask

   function automatic logic [NP*DW-1:0] opnd_from_sel(input logic [2*NP-1:0] sel);
      logic [NP*DW-1:0] o;
      for (int p = 0; p < NP; p++) begin
         case (sel[2*p +: 2])
            2'b01:   o[p*DW +: DW] = alu_out_m;
            2'b10:   o[p*DW +: DW] = result_w;
            default: o[p*DW +: DW] = d_rd[p*DW +: DW];
         endcase
      end
      return o;
   endfunction

   // Instructions are classified by age since issue: 1 = EX, 2 = MEM, 3 = WB
   task automatic model_eval(output logic ms, output logic [2*NP-1:0] msel,
                             output logic [NP*DW-1:0] mop);
      logic [AW-1:0] ra;
      bit in_ex, alu_mem, ld_mem, in_wb;
      ms = 1'b0; msel = '0;
      for (int p = 0; p < NP; p++) begin
         ra = d_ra[p*AW +: AW];
         in_ex = 0; alu_mem = 0; ld_mem = 0; in_wb = 0;
         if (d_use[p] && ra != 0 && rst_n) begin
            foreach (q[i]) begin
               if (q[i].we && q[i].wa == ra) begin
                  if (q[i].age == 1) in_ex = 1;
                  else if (q[i].age == 2 && q[i].ld) ld_mem = 1;
                  else if (q[i].age == 2) alu_mem = 1;
                  else if (q[i].age == 3) in_wb = 1;
               end
            end
            if (in_ex || ld_mem) ms = 1'b1;
            if (alu_mem) msel[2*p +: 2] = 2'b01;
            else if (in_wb) msel[2*p +: 2] = 2'b10;
         end
      end
      ms = ms & d_valid;
      mop = opnd_from_sel(msel);
   endtask

   task automatic model_update(input logic ms);
      inflight_t e;
      if (!rst_n) begin
         q.delete(); m_cnt = 16'h0;
         return;
      end
      if (ms && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      foreach (q[i]) q[i].age = q[i].age + 1;
      while (q.size() > 0 && q[0].age > 3) void'(q.pop_front());
      if (d_valid && !ms && !flush_e) begin
         e.we = d_we; e.wa = d_wa; e.ld = d_load; e.age = 1;
         q.push_back(e);
      end
   endtask

   task automatic step(input bit tbl_mode, input logic es, input logic [2*NP-1:0] esel,
                       input string nm);
      logic ms;
      logic [2*NP-1:0] msel;
      logic [NP*DW-1:0] mop;
      @(negedge clk);
      model_eval(ms, msel, mop);
      if (tbl_mode) begin
         chk({nm, "_stall"}, 64'(stall_d), 64'(es));
         chk({nm, "_sel"}, 64'(fwd_sel), 64'(esel));
         chk({nm, "_opnd"}, 64'(d_opnd), 64'(opnd_from_sel(esel)));
      end else begin
         chk({nm, "_stall"}, 64'(stall_d), 64'(ms));
         chk({nm, "_sel"}, 64'(fwd_sel), 64'(msel));
         chk({nm, "_opnd"}, 64'(d_opnd), 64'(mop));
      end
`ifdef DECODE_FWD_STALL_CNT_EN
      chk({nm, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
`endif
      @(posedge clk);
      model_update(ms);
      #1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; m_cnt = 16'h0;
      rst_n = 1'b0;
      set_in(1, 1, 3, 0, 3, 3, 3, 0);
      d_rd = {RD1, RD0}; alu_out_m = ALU; result_w = RES;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", 64'(stall_d), 64'(0));
      chk("reset_sel", 64'(fwd_sel), 64'(0));
      chk("reset_opnd", 64'(d_opnd), 64'(d_rd));
`ifdef DECODE_FWD_STALL_CNT_EN
      chk("reset_cnt", 64'(stall_cnt), 64'(0));
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      //        v we wa ld ra0 ra1 use fl | stall sel
      add_row(1, 1, 3, 0, 0, 0, 0, 0, 0, 4'b0000); // ALU writes r3
      add_row(1, 0, 0, 0, 3, 0, 1, 0, 1, 4'b0000); // r3 in EX: stall
      add_row(1, 0, 0, 0, 3, 0, 1, 0, 0, 4'b0001); // r3 in MEM: forward ALU
      add_row(1, 1, 4, 1, 0, 0, 0, 0, 0, 4'b0000); // load r4
      add_row(1, 0, 0, 0, 0, 4, 2, 0, 1, 4'b0000); // load in EX
      add_row(1, 0, 0, 0, 0, 4, 2, 0, 1, 4'b0000); // load in MEM
      add_row(1, 0, 0, 0, 0, 4, 2, 0, 0, 4'b1000); // load in WB: forward result
      add_row(1, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0000); // write r5
      add_row(1, 1, 6, 0, 1, 2, 3, 0, 0, 4'b0000); // independent
      add_row(1, 0, 0, 0, 5, 0, 1, 0, 0, 4'b0001); // r5 from MEM, no stall
      add_row(1, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0000); // write r5 (older)
      add_row(1, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0000); // write r5 (newer)
      add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000); // bubble
      add_row(1, 0, 0, 0, 5, 5, 3, 0, 0, 4'b0101); // MEM beats WB on both ports
      add_row(1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000); // write r0
      add_row(1, 0, 0, 0, 0, 0, 3, 0, 0, 4'b0000); // r0 in EX: no stall
      add_row(1, 0, 0, 0, 0, 0, 3, 0, 0, 4'b0000); // r0 in MEM: no forward
      add_row(1, 1, 7, 1, 0, 0, 0, 0, 0, 4'b0000); // load r7
      add_row(1, 0, 0, 0, 7, 0, 1, 1, 1, 4'b0000); // stall together with flush
      add_row(0, 0, 0, 0, 7, 0, 1, 0, 0, 4'b0000); // invalid decode never stalls
      add_row(1, 0, 0, 0, 7, 7, 1, 0, 0, 4'b0010); // port 1 unused stays on RF
      add_row(1, 1, 9, 0, 0, 0, 0, 1, 0, 4'b0000); // flushed write r9
      add_row(1, 0, 0, 0, 9, 0, 1, 0, 0, 4'b0000); // flushed r9 never produces

      foreach (tbl[i]) begin
         set_in(int'(tbl[i].v), int'(tbl[i].we), int'(tbl[i].wa), int'(tbl[i].ld),
                int'(tbl[i].ra0), int'(tbl[i].ra1), int'(tbl[i].usem), int'(tbl[i].fl));
         step(1'b1, tbl[i].es, tbl[i].esel, $sformatf("row%0d", i));
      end

      // Reset pulse while a load sits in EX
      set_in(1, 1, 4, 1, 0, 0, 0, 0);
      step(1'b1, 1'b0, 4'b0000, "rstseq_load");
      set_in(1, 0, 0, 0, 0, 4, 2, 0);
      @(negedge clk);
      chk("rstseq_stall_pre", 64'(stall_d), 64'(1));
      #1 rst_n = 1'b0;
      q.delete(); m_cnt = 16'h0;
      #1;
      chk("rstseq_stall_in", 64'(stall_d), 64'(0));
      chk("rstseq_sel_in", 64'(fwd_sel), 64'(0));
      chk("rstseq_opnd_in", 64'(d_opnd), 64'(d_rd));
`ifdef DECODE_FWD_STALL_CNT_EN
      chk("rstseq_cnt_in", 64'(stall_cnt), 64'(0));
`endif
      #1 rst_n = 1'b1;
      #1;
      chk("rstseq_sel_post", 64'(fwd_sel), 64'(0));
      chk("rstseq_stall_post", 64'(stall_d), 64'(0));
      @(posedge clk);
      model_update(1'b0);
      #1;
      step(1'b0, 1'b0, 4'b0000, "rstseq_next");

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         if (!rst_n) begin
            q.delete(); m_cnt = 16'h0;
         end
         set_in(int'($urandom_range(0, 99) < 85), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 99) < 30),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 99) < 10));
         d_rd = {$urandom, $urandom};
         alu_out_m = $urandom;
         result_w = $urandom;
         step(1'b0, 1'b0, 4'b0000, $sformatf("rand%0d", n));
      end
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
